match_controller: RTL and testbench

Referee for the quidditch game: consumes the ball controller's `blue_score_up` / `red_score_up` toggle outputs, keeps both team scores and decides when play stops and restarts. It drives the ball controller's `game_initiated` / `game_over` inputs. It sits between the ball controller and the score display / VGA overlay.

---
 rtl/quidditch_pkg.sv | 22 ++
 rtl/toggle_edge_detect.sv | 25 ++
 rtl/match_controller.sv | 148 ++++++++++++++
 tb/tb_match_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/quidditch_pkg.sv
// Shared types for the quidditch match logic.
//   phase_e : FSM state codes, also exported to the score display.
//   WIN_*   : winner encoding presented on match_controller.winner.
package quidditch_pkg;

  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned WINNER_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAYING    = 3'd2,
    GOAL_PAUSE = 3'd3,
    OVER       = 3'd4
  } phase_e;

  localparam logic [WINNER_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WINNER_W-1:0] WIN_BLUE = 2'b01;
  localparam logic [WINNER_W-1:0] WIN_RED  = 2'b10;
  localparam logic [WINNER_W-1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/toggle_edge_detect.sv
// Turns a toggle-encoded event line into a one-cycle event flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   tog_in     : toggle input, every level change is one event
//   edge_out   : combinational, high while tog_in differs from its last sampled level
module toggle_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  output logic edge_out
);

  logic prev;

  // Sampled unconditionally so events outside play are absorbed rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= tog_in;
    end
  end

  assign edge_out = tog_in ^ prev;

endmodule

// File: rtl/match_controller.sv
// Match referee: counts goals from the ball controller's toggle outputs,
// sequences serve pauses and decides the winner.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle start/restart pulse (honoured in IDLE/OVER only)
//   blue/red_score_up    : goal toggles from the ball controller
//   game_initiated       : one-cycle ball release pulse
//   game_over            : high while the ball must stay dead at centre
//   blue/red_score       : current match scores (saturating)
//   winner               : WIN_NONE / WIN_BLUE / WIN_RED / WIN_DRAW
//   phase                : current FSM state code
module match_controller
  import quidditch_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               blue_score_up,
  input  logic               red_score_up,
  output logic               game_initiated,
  output logic               game_over,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic [1:0]         winner,
  output logic [2:0]         phase
);

  localparam int unsigned        TIMER_W    = $clog2(SERVE_DELAY + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  phase_e               state, state_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [SCORE_W-1:0]   blue_next, red_next;
  logic [1:0]           winner_next;
  logic                 over_next, init_next;

  logic                 blue_goal, red_goal;
  logic [SCORE_W-1:0]   blue_inc, red_inc;
  logic [SCORE_W-1:0]   blue_cand, red_cand;
  logic                 blue_win, red_win;

  // Goal event decoders
  toggle_edge_detect u_blue_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .tog_in   (blue_score_up),
    .edge_out (blue_goal)
  );

  toggle_edge_detect u_red_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .tog_in   (red_score_up),
    .edge_out (red_goal)
  );

  // Saturating increments and win detection on the would-be new scores
  assign blue_inc  = (blue_score == '1) ? blue_score : blue_score + SCORE_W'(1);
  assign red_inc   = (red_score  == '1) ? red_score  : red_score  + SCORE_W'(1);
  assign blue_cand = blue_goal ? blue_inc : blue_score;
  assign red_cand  = red_goal  ? red_inc  : red_score;
  assign blue_win  = blue_goal && (blue_cand >= WIN_VAL);
  assign red_win   = red_goal  && (red_cand  >= WIN_VAL);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      timer          <= '0;
      blue_score     <= '0;
      red_score      <= '0;
      winner         <= WIN_NONE;
      game_over      <= 1'b1;
      game_initiated <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      blue_score     <= blue_next;
      red_score      <= red_next;
      winner         <= winner_next;
      game_over      <= over_next;
      game_initiated <= init_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    blue_next   = blue_score;
    red_next    = red_score;
    winner_next = winner;
    init_next   = 1'b0;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_next  = SERVE_WAIT;
          timer_next  = TIMER_LOAD;
          blue_next   = '0;
          red_next    = '0;
          winner_next = WIN_NONE;
        end
      end

      // The release pulse is issued from the pause state itself; play begins
      // on the edge that ends it, so the pulse is exactly one cycle wide.
      SERVE_WAIT, GOAL_PAUSE: begin
        if (game_initiated) begin
          state_next = PLAYING;
        end else if (timer == '0) begin
          init_next = 1'b1;
        end else begin
          timer_next = timer - TIMER_W'(1);
        end
      end

      PLAYING: begin
        if (blue_goal || red_goal) begin
          blue_next = blue_cand;
          red_next  = red_cand;
          if (blue_win || red_win) begin
            state_next  = OVER;
            winner_next = (blue_win && red_win) ? WIN_DRAW :
                          blue_win              ? WIN_BLUE : WIN_RED;
          end else begin
            state_next = GOAL_PAUSE;
            timer_next = TIMER_LOAD;
          end
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    over_next = (state_next == IDLE) || (state_next == OVER);
  end

  assign phase = state;

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller (WIN_SCORE=3, SERVE_DELAY=4).
module tb_match_controller;
  import quidditch_pkg::*;

  localparam int unsigned WIN_SCORE   = 3;
  localparam int unsigned SERVE_DELAY = 4;
  localparam int unsigned SCORE_W     = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               blue_tog;
  logic               red_tog;
  logic               game_initiated;
  logic               game_over;
  logic [SCORE_W-1:0] blue_score;
  logic [SCORE_W-1:0] red_score;
  logic [1:0]         winner;
  logic [2:0]         phase;

  int n_checks = 0;
  int n_fail   = 0;

  match_controller #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_DELAY (SERVE_DELAY),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .blue_score_up  (blue_tog),
    .red_score_up   (red_tog),
    .game_initiated (game_initiated),
    .game_over      (game_over),
    .blue_score     (blue_score),
    .red_score      (red_score),
    .winner         (winner),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ph, input int bs, input int rs,
                         input int win, input int over, input int init);
    check({tag, ".phase"},  32'(phase),          32'(ph));
    check({tag, ".blue"},   32'(blue_score),     32'(bs));
    check({tag, ".red"},    32'(red_score),      32'(rs));
    check({tag, ".winner"}, 32'(winner),         32'(win));
    check({tag, ".over"},   32'(game_over),      32'(over));
    check({tag, ".init"},   32'(game_initiated), 32'(init));
  endtask

  // Pause began 'done' edges ago; release pulse follows SERVE_DELAY edges after it.
  task automatic release_chk(input string tag, input int done);
    for (int k = done + 1; k <= int'(SERVE_DELAY) + 1; k++) begin
      step();
      check({tag, ".init_k"}, 32'(game_initiated), (k == int'(SERVE_DELAY)) ? 32'd1 : 32'd0);
      check({tag, ".over_k"}, 32'(game_over), 32'd0);
    end
    check({tag, ".playing"}, 32'(phase), 32'(PLAYING));
  endtask

  task automatic goal(input logic b, input logic r);
    if (b) blue_tog = ~blue_tog;
    if (r) red_tog  = ~red_tog;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gi_cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    blue_tog = 1'b0;
    red_tog  = 1'b0;
    #12;
    chk_all("reset", IDLE, 0, 0, WIN_NONE, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("idle", IDLE, 0, 0, WIN_NONE, 1, 0);

    // Start from IDLE
    pulse_start();
    chk_all("start", SERVE_WAIT, 0, 0, WIN_NONE, 0, 0);
    release_chk("serve1", 0);

    // Single goal and absorbed re-toggle
    goal(1'b1, 1'b0);
    chk_all("goal1", GOAL_PAUSE, 1, 0, WIN_NONE, 0, 0);
    goal(1'b1, 1'b0);
    check("retoggle.blue", 32'(blue_score), 32'd1);
    release_chk("pause1", 1);

    // Blue wins 3-0
    goal(1'b1, 1'b0);
    chk_all("goal2", GOAL_PAUSE, 2, 0, WIN_NONE, 0, 0);
    release_chk("pause2", 0);
    goal(1'b1, 1'b0);
    chk_all("bluewin", OVER, 3, 0, WIN_BLUE, 1, 0);
    gi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (game_initiated) gi_cnt++;
    end
    check("over.no_init", 32'(gi_cnt), 32'd0);
    chk_all("over.hold", OVER, 3, 0, WIN_BLUE, 1, 0);

    // Restart from OVER, then start during play is ignored
    pulse_start();
    chk_all("restart", SERVE_WAIT, 0, 0, WIN_NONE, 0, 0);
    release_chk("serve2", 0);
    pulse_start();
    chk_all("start_in_play", PLAYING, 0, 0, WIN_NONE, 0, 0);

    // Build 2-2; one goal arrives together with start
    goal(1'b1, 1'b0);
    release_chk("p_b1", 0);
    start = 1'b1;
    goal(1'b0, 1'b1);
    start = 1'b0;
    chk_all("goal_and_start", GOAL_PAUSE, 1, 1, WIN_NONE, 0, 0);
    release_chk("p_r1", 0);
    goal(1'b1, 1'b0);
    release_chk("p_b2", 0);
    goal(1'b0, 1'b1);
    chk_all("two_two", GOAL_PAUSE, 2, 2, WIN_NONE, 0, 0);
    release_chk("p_r2", 0);
    goal(1'b1, 1'b1);
    chk_all("draw", OVER, 3, 3, WIN_DRAW, 1, 0);

    // Reset during GOAL_PAUSE with red on 2
    pulse_start();
    release_chk("serve3", 0);
    goal(1'b0, 1'b1);
    release_chk("p_r3", 0);
    goal(1'b0, 1'b1);
    chk_all("red_two", GOAL_PAUSE, 0, 2, WIN_NONE, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk_all("midreset", IDLE, 0, 0, WIN_NONE, 1, 0);
    step();
    step();
    rst_n = 1'b1;
    gi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (game_initiated) gi_cnt++;
    end
    check("post_reset.no_init", 32'(gi_cnt), 32'd0);
    chk_all("post_reset", IDLE, 0, 0, WIN_NONE, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
